// File: rtl/en_bitpack_pkg.sv
// Shared types and constants for the entropy-coder bitstream packer.
package en_bitpack_pkg;

  typedef enum logic [1:0] {
    StRun,
    StPad,
    StDrain
  } state_e;

  localparam int unsigned ACC_W       = 32;
  localparam int unsigned CNT_W       = 6;
  localparam logic [7:0]  STUFF_BYTE  = 8'h00;
  localparam logic [7:0]  MARKER_BYTE = 8'hFF;

endpackage

// File: rtl/bp_mask.sv
// Left-aligned ones mask: the top `len` bits set; len >= IN_W gives all ones.
module bp_mask #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned LEN_W = 5
) (
  input  logic [LEN_W-1:0] len,
  output logic [IN_W-1:0]  mask
);

  assign mask = ~({IN_W{1'b1}} >> len);

endmodule

// File: rtl/en_bitpack.sv
// MSB-first bitstream packer with 0xFF/0x00 byte stuffing and flush padding.
// Optional byte counter output enabled by defining EN_BITPACK_BYTE_CNT_EN.
module en_bitpack
  import en_bitpack_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic [LEN_W-1:0] in_len,
  input  logic             flush,
  output logic             flush_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data
`ifdef EN_BITPACK_BYTE_CNT_EN
  ,
  output logic [31:0]      byte_cnt
`endif
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_post;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_post;
  logic               stuff_q, stuff_d;
  logic               flush_done_q, flush_done_d;

  logic               pop, pop_acc, accept;
  logic [LEN_W-1:0]   len_eff, pad_len;
  logic [2:0]         pad_bits;
  logic [IN_W-1:0]    code_mask, pad_mask;
  logic [ACC_W-1:0]   code_word, pad_word;

  assign len_eff = (in_len > LEN_W'(IN_W)) ? LEN_W'(IN_W) : in_len;

  bp_mask #(
    .IN_W  (IN_W),
    .LEN_W (LEN_W)
  ) u_code_mask (
    .len  (len_eff),
    .mask (code_mask)
  );

  bp_mask #(
    .IN_W  (IN_W),
    .LEN_W (LEN_W)
  ) u_pad_mask (
    .len  (pad_len),
    .mask (pad_mask)
  );

  assign pop     = out_valid && out_ready;
  assign pop_acc = pop && !stuff_q;
  assign accept  = in_valid && in_ready;

  // Datapath: pop first, then insert code or pad bits at the post-pop position.
  always_comb begin
    acc_post  = pop_acc ? (acc_q << 8) : acc_q;
    cnt_post  = pop_acc ? (cnt_q - CNT_W'(8)) : cnt_q;
    pad_bits  = 3'd0 - cnt_post[2:0];
    pad_len   = LEN_W'(pad_bits);
    code_word = {in_code & code_mask, {(ACC_W-IN_W){1'b0}}};
    pad_word  = {pad_mask, {(ACC_W-IN_W){1'b0}}};

    stuff_d = stuff_q;
    if (pop) begin
      stuff_d = stuff_q ? 1'b0 : (acc_q[ACC_W-1 -: 8] == MARKER_BYTE);
    end

    acc_d = acc_post;
    cnt_d = cnt_post;
    if (accept) begin
      acc_d = acc_post | (code_word >> cnt_post);
      cnt_d = cnt_post + CNT_W'(len_eff);
    end else if (state_q == StPad) begin
      acc_d = acc_post | (pad_word >> cnt_post);
      cnt_d = cnt_post + CNT_W'(pad_bits);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      stuff_q      <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      stuff_q      <= stuff_d;
      flush_done_q <= flush_done_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush && in_ready) state_d = StPad;
      StPad:   state_d = StDrain;
      StDrain: if (cnt_q == '0 && !stuff_q) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // FSM / datapath outputs
  always_comb begin
    in_ready     = (state_q == StRun) && (cnt_q <= CNT_W'(ACC_W - IN_W));
    out_valid    = stuff_q || (cnt_q >= CNT_W'(8));
    out_data     = stuff_q ? STUFF_BYTE : acc_q[ACC_W-1 -: 8];
    flush_done_d = (state_q == StDrain) && (cnt_q == '0) && !stuff_q;
  end

  assign flush_done = flush_done_q;

`ifdef EN_BITPACK_BYTE_CNT_EN
  logic [31:0] byte_cnt_q;

  // Holds the total through the flush_done cycle, then restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
    end else if (flush_done_q) begin
      byte_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_q + 32'(pop);
    end
  end

  assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_en_bitpack.sv
// Self-checking bench for en_bitpack: bit-queue reference model plus directed vectors.
module tb_en_bitpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_code = '0;
  logic [4:0]  in_len = '0;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
`ifdef EN_BITPACK_BYTE_CNT_EN
  logic [31:0] byte_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  en_bitpack #(
    .IN_W  (16),
    .LEN_W (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_len     (in_len),
    .flush      (flush),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef EN_BITPACK_BYTE_CNT_EN
    ,
    .byte_cnt   (byte_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference model: pending stream bits as a queue, plus flush mode and stuff flag.
  bit         mq[$];
  bit         m_stuff = 1'b0;
  int         m_mode = 0;  // 0 accepting, 1 padding, 2 draining
  bit         m_done = 1'b0;
  int         m_bc = 0;
  logic [7:0] got[$];
  bit         m_er, m_ev, m_pop, m_pre_stuff;
  int         m_pre_size, m_n;
  logic [7:0] m_eb;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      got.delete();
      m_stuff = 1'b0;
      m_mode  = 0;
      m_done  = 1'b0;
      m_bc    = 0;
    end else begin
      m_er = (m_mode == 0) && (mq.size() <= 16);
      m_ev = m_stuff || (mq.size() >= 8);
      m_eb = 8'h00;
      if (!m_stuff && mq.size() >= 8)
        for (int i = 0; i < 8; i++) m_eb[7-i] = mq[i];
      check("in_ready", {31'b0, in_ready}, {31'b0, m_er});
      check("out_valid", {31'b0, out_valid}, {31'b0, m_ev});
      check("flush_done", {31'b0, flush_done}, {31'b0, m_done});
      if (m_ev) check("out_data", {24'b0, out_data}, {24'b0, m_eb});
`ifdef EN_BITPACK_BYTE_CNT_EN
      check("byte_cnt", byte_cnt, m_bc);
`endif
      m_pop       = m_ev && out_ready;
      m_pre_size  = mq.size();
      m_pre_stuff = m_stuff;
      if (m_pop) begin
        got.push_back(out_data);
        if (m_stuff) m_stuff = 1'b0;
        else begin
          for (int i = 0; i < 8; i++) void'(mq.pop_front());
          m_stuff = (m_eb == 8'hFF);
        end
      end
      if (in_valid && m_er) begin
        m_n = (in_len > 5'd16) ? 16 : int'(in_len);
        for (int i = 0; i < m_n; i++) mq.push_back(in_code[15-i]);
      end
      m_bc   = m_done ? 0 : m_bc + int'(m_pop);
      m_done = 1'b0;
      case (m_mode)
        0: if (flush && m_er) m_mode = 1;
        1: begin
          while (mq.size() % 8 != 0) mq.push_back(1'b1);
          m_mode = 2;
        end
        default: if (m_pre_size == 0 && !m_pre_stuff) begin
          m_mode = 0;
          m_done = 1'b1;
        end
      endcase
    end
  end

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return {24'b0, got[i]};
    return 32'hFFFF_FFFF;
  endfunction

  // All tasks start and end at posedge + 1.
  task automatic send(input logic [15:0] c, input logic [4:0] l);
    in_code  = c;
    in_len   = l;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    fail("send_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!out_valid) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(output int cycles);
    cycles = 0;
    flush  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cycles++;
      if (flush_done) break;
      check("flush_in_ready_low", {31'b0, in_ready}, 32'd0);
    end
    if (!flush_done) fail("flush_done_timeout");
    @(posedge clk);
    #1;
  endtask

  int base;
  int cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {24'b0, out_data}, 32'h00);
    check("rst_flush_done", {31'b0, flush_done}, 32'd0);

    // 101 + 11111 -> 0xBF
    out_ready = 1'b1;
    base = got.size();
    send(16'hA000, 5'd3);
    send(16'hF800, 5'd5);
    wait_idle();
    check("t1_count", got.size() - base, 32'd1);
    check("t1_b0", got_at(base), 32'hBF);
    check("t1_empty", {31'b0, out_valid}, 32'd0);

    // 0xFF is followed by a stuff byte before 0x12
    base = got.size();
    send(16'hFF00, 5'd8);
    send(16'h1200, 5'd8);
    wait_idle();
    check("t2_count", got.size() - base, 32'd3);
    check("t2_b0", got_at(base), 32'hFF);
    check("t2_b1", got_at(base + 1), 32'h00);
    check("t2_b2", got_at(base + 2), 32'h12);

    // 010 then flush -> 010_11111
    base = got.size();
    send(16'h4000, 5'd3);
    do_flush(cyc);
    check("t3_count", got.size() - base, 32'd1);
    check("t3_b0", got_at(base), 32'h5F);

    // Back-pressure: third 16-bit code waits, head byte holds
    out_ready = 1'b0;
    base = got.size();
    send(16'h1234, 5'd16);
    send(16'h5678, 5'd16);
    in_code  = 16'h9ABC;
    in_len   = 5'd16;
    in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("t4_stall_ready", {31'b0, in_ready}, 32'd0);
      check("t4_stall_data", {24'b0, out_data}, 32'h12);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h9ABC, 5'd16);
    wait_idle();
    check("t4_count", got.size() - base, 32'd6);
    check("t4_b0", got_at(base), 32'h12);
    check("t4_b3", got_at(base + 3), 32'h78);
    check("t4_b5", got_at(base + 5), 32'hBC);

    // Accept and pop in the same cycle at cnt=8
    out_ready = 1'b0;
    base = got.size();
    send(16'h3C00, 5'd8);
    out_ready = 1'b1;
    in_code   = 16'hAB00;
    in_len    = 5'd8;
    in_valid  = 1'b1;
    @(negedge clk);
    check("t5_both_ready", {30'b0, in_ready, out_valid}, 32'd3);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t5_valid", {31'b0, out_valid}, 32'd1);
    check("t5_data", {24'b0, out_data}, 32'hAB);
    out_ready = 1'b1;
    wait_idle();
    check("t5_count", got.size() - base, 32'd2);
    check("t5_b0", got_at(base), 32'h3C);
    check("t5_b1", got_at(base + 1), 32'hAB);

    // len 0 is a no-op, len > 16 behaves as 16; then flush with nothing buffered
    base = got.size();
    send(16'hFFFF, 5'd0);
    send(16'hABCD, 5'd20);
    wait_idle();
    check("t6_count", got.size() - base, 32'd2);
    check("t6_b0", got_at(base), 32'hAB);
    check("t6_b1", got_at(base + 1), 32'hCD);
    do_flush(cyc);
    check("t6_empty_flush_cycles", cyc, 32'd3);
    check("t6_empty_flush_bytes", got.size() - base, 32'd2);

    // Reset with cnt=13 and a pending stuff byte
    out_ready = 1'b0;
    send(16'hFF00, 5'd8);
    send(16'hFFF8, 5'd13);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t7_stuff_pending", {23'b0, out_valid, out_data}, 32'h100);
    #1 rst_n = 1'b0;
    #1;
    check("t7_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t7_rst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t7_no_stale", got.size(), 32'd0);
    check("t7_ready_after", {31'b0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
